// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control unit.
//   - state encodings (5-bit, legacy-compatible localparams)
//   - opcode / funct constants for the supported instruction subset
//   - alu_op codes and datapath mux selector encodings
//   - instruction-class enum produced by mips_ctrl_decode
package mips_ctrl_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_RESET      = 5'd0;
  localparam state_t S_FETCH      = 5'd1;
  localparam state_t S_FETCH_WAIT = 5'd2;
  localparam state_t S_IR_LOAD    = 5'd3;
  localparam state_t S_DECODE     = 5'd4;
  localparam state_t S_MEM_ADDR   = 5'd5;
  localparam state_t S_MEM_READ   = 5'd6;
  localparam state_t S_MEM_WAIT   = 5'd7;
  localparam state_t S_MEM_WB     = 5'd8;
  localparam state_t S_MEM_WRITE  = 5'd9;
  localparam state_t S_R_EXEC     = 5'd10;
  localparam state_t S_R_WB       = 5'd11;
  localparam state_t S_ADDI_EXEC  = 5'd12;
  localparam state_t S_ADDI_WB    = 5'd13;
  localparam state_t S_BRANCH     = 5'd14;
  localparam state_t S_JUMP       = 5'd15;
  localparam state_t S_EXC        = 5'd16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic       IORD_PC     = 1'b0;
  localparam logic       IORD_ALUOUT = 1'b1;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] ALUB_B    = 2'b00;
  localparam logic [1:0] ALUB_4    = 2'b01;
  localparam logic [1:0] ALUB_SE   = 2'b10;
  localparam logic [1:0] ALUB_SESH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_LW, CL_SW, CL_ADDI, CL_BEQ, CL_BNE, CL_J, CL_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational instruction classifier.
//   in  opcode[5:0], funct[5:0]
//   out iclass (instruction class), alu_op (R-type ALU function; add otherwise)
// R-type with an unsupported funct is reported as CL_ILLEGAL.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [2:0] alu_op
);

  always_comb begin
    iclass = CL_ILLEGAL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin iclass = CL_RTYPE; alu_op = ALU_ADD; end
          FN_SUB:  begin iclass = CL_RTYPE; alu_op = ALU_SUB; end
          FN_AND:  begin iclass = CL_RTYPE; alu_op = ALU_AND; end
          FN_XOR:  begin iclass = CL_RTYPE; alu_op = ALU_XOR; end
          default: iclass = CL_ILLEGAL;
        endcase
      end
      OP_J:    iclass = CL_J;
      OP_BEQ:  iclass = CL_BEQ;
      OP_BNE:  iclass = CL_BNE;
      OP_ADDI: iclass = CL_ADDI;
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multicycle MIPS control unit.
//   in  clk, reset (async, active high), opcode, funct, zero, overflow
//   out mux selectors (iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
//       pc_source), alu_op, write enables (pc_write, mem_write, ir_write,
//       reg_write, epc_write), state_dbg (current state encoding)
// Config macro: MIPS_EXCEPTION_EN adds the EXC state (illegal instruction
// and add/sub/addi overflow trap). Without it epc_write is tied low.
// All outputs are Moore except pc_write in BRANCH, which follows zero.
module mips_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic [4:0] state_dbg
);

  state_t     state, nxt;
  iclass_t    iclass;
  logic [2:0] dec_alu_op;

  mips_ctrl_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass),
    .alu_op (dec_alu_op)
  );

`ifndef MIPS_EXCEPTION_EN
  // overflow has no effect without the exception path
  logic unused_ovf;
  assign unused_ovf = overflow;
`endif

  // Async reset drops state to RESET, whose output decode is all-zero, so
  // any in-flight write strobe is killed without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_RESET;
    else       state <= nxt;

  always_comb begin
    nxt = S_RESET;
    case (state)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: nxt = S_IR_LOAD;
      S_IR_LOAD:    nxt = S_DECODE;
      S_DECODE: begin
        case (iclass)
          CL_LW, CL_SW:   nxt = S_MEM_ADDR;
          CL_RTYPE:       nxt = S_R_EXEC;
          CL_ADDI:        nxt = S_ADDI_EXEC;
          CL_BEQ, CL_BNE: nxt = S_BRANCH;
          CL_J:           nxt = S_JUMP;
`ifdef MIPS_EXCEPTION_EN
          default:        nxt = S_EXC;
`else
          default:        nxt = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:   nxt = (iclass == CL_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:   nxt = S_MEM_WAIT;
      S_MEM_WAIT:   nxt = S_MEM_WB;
      S_MEM_WB:     nxt = S_FETCH;
      S_MEM_WRITE:  nxt = S_FETCH;
      S_R_EXEC: begin
        nxt = S_R_WB;
`ifdef MIPS_EXCEPTION_EN
        // logical ops cannot overflow; only add/sub trap
        if (overflow && (dec_alu_op == ALU_ADD || dec_alu_op == ALU_SUB))
          nxt = S_EXC;
`endif
      end
      S_R_WB:       nxt = S_FETCH;
      S_ADDI_EXEC: begin
        nxt = S_ADDI_WB;
`ifdef MIPS_EXCEPTION_EN
        if (overflow) nxt = S_EXC;
`endif
      end
      S_ADDI_WB:    nxt = S_FETCH;
      S_BRANCH:     nxt = S_FETCH;
      S_JUMP:       nxt = S_FETCH;
`ifdef MIPS_EXCEPTION_EN
      S_EXC:        nxt = S_FETCH;
`endif
      default:      nxt = S_RESET;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = IORD_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_B;
    alu_op     = 3'b000;
    pc_source  = PCSRC_ALU;
    epc_write  = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b = ALUB_4;
        alu_op    = ALU_ADD;
        pc_write  = 1'b1;
      end
      S_IR_LOAD: ir_write = 1'b1;
      S_DECODE: begin
        alu_src_b = ALUB_SESH;
        alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_SE;
        alu_op    = ALU_ADD;
      end
      // keep ALUOut on the address bus through the read latency cycle
      S_MEM_READ, S_MEM_WAIT: iord = IORD_ALUOUT;
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        iord      = IORD_ALUOUT;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      S_R_WB: begin
        reg_dst   = REGDST_RD;
        reg_write = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = (iclass == CL_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
`ifdef MIPS_EXCEPTION_EN
      S_EXC: begin
        epc_write = 1'b1;
        pc_source = PCSRC_EXC;
        pc_write  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multicycle MIPS control unit that sequences fetch, decode, execute, memory and write-back for each instruction. It is the stage directly upstream of the datapath multiplexers: it produces every mux selector (IorD, ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg) plus all register, memory and PC write enables. Its inputs are the current instruction fields and the ALU flags.

## Interface
Parameters:
- none; all encodings come from `mips_ctrl_pkg`.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]; valid from the DECODE state onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational from the current ALU inputs.
- `overflow` in 1: ALU signed-overflow flag.
- `pc_write` out 1: PC load enable. In BRANCH only, it depends on `zero` (Mealy).
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: IR load enable.
- `reg_dst` out 2: write-register select; 00 = rt, 01 = rd, 10 = r31.
- `mem_to_reg` out 1: write-data select; 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A input; 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B input; 00 = B, 01 = const 4, 10 = signext, 11 = signext<<2.
- `alu_op` out 3: ALU function; 001 = add, 010 = sub, 011 = and, 110 = xor.
- `pc_source` out 2: PC input; 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- `epc_write` out 1: EPC load enable. Driven 0 when `EXCEPTION_EN` is not defined.
- `state_dbg` out 5: current state encoding.

## Operation
- Outputs other than `pc_write` in BRANCH are Moore: decoded from the state register only.
- Every output not listed for a state is 0.
- States and their transitions:
  - RESET → FETCH.
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00, pc_write=1. Next: FETCH_WAIT.
  - FETCH_WAIT: memory read latency; no outputs. Next: IR_LOAD.
  - IR_LOAD: ir_write=1. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALUOut). Next state by class:
    - lw/sw → MEM_ADDR
    - R-type → R_EXEC
    - addi → ADDI_EXEC
    - beq/bne → BRANCH
    - j → JUMP
    - otherwise → ILLEGAL handling
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. Next: lw → MEM_READ, sw → MEM_WRITE.
  - MEM_READ: iord=1. Next: MEM_WAIT, then MEM_WB.
  - MEM_WB: reg_dst=00, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEM_WRITE: iord=1, mem_write=1. Next: FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct. Next: R_WB.
  - R_WB: reg_dst=01, reg_write=1. Next: FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=add. Next: ADDI_WB.
  - ADDI_WB: reg_dst=00, reg_write=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01. pc_write = zero for beq, !zero for bne. Next: FETCH.
  - JUMP: pc_source=10, pc_write=1. Next: FETCH.
- Supported opcodes: R-type=0x00, j=0x02, beq=0x04, bne=0x05, addi=0x08, lw=0x23, sw=0x2B.
- Supported funct values (R-type): add=0x20, sub=0x22, and=0x24, xor=0x26.
- An R-type instruction with any other funct is treated as an illegal opcode.

## Timing
- Cycles per instruction, including the 4-cycle fetch/decode:
  - j, beq, bne: 5
  - R-type, addi, sw: 6
  - lw: 8
- Illegal opcode: 4 cycles without `EXCEPTION_EN` (behaves as a NOP); 5 cycles with it.
- Reset asserted in any state, including mid-instruction:
  - state goes to RESET immediately; all outputs go to 0 asynchronously.
  - No partial write may complete after reset is asserted.
  - RESET is held one cycle after deassertion, then FETCH.
- `zero` and `overflow` are sampled only in BRANCH, R_EXEC and ADDI_EXEC.
- `opcode` and `funct` must be stable from DECODE until the instruction returns to FETCH.

## Configuration
- `MIPS_EXCEPTION_EN` defined:
  - Adds state EXC: epc_write=1, pc_source=11, pc_write=1; next state FETCH.
  - An illegal opcode/funct in DECODE goes to EXC.
  - In R_EXEC with add/sub, or in ADDI_EXEC, overflow=1 goes to EXC instead of the write-back state, so no register write occurs.
- Not defined: EXC is absent, `epc_write` is tied to 0, illegal instructions return to FETCH, and overflow is ignored.

## Structure
- `mips_ctrl_pkg` contains:
  - the state enum;
  - opcode and funct constants;
  - alu_op codes;
  - selector encodings for iord, reg_dst, alu_src_b and pc_source.
- Sub-module `mips_ctrl_decode`: combinational, maps opcode/funct to an instruction-class enum and alu_op. The FSM instantiates it once.

## Test plan
- Reset mid-MEM_WRITE → mem_write drops to 0 with no clock edge; after release, one RESET cycle, then FETCH with pc_write=1 and alu_src_b=01.
- lw (opcode 0x23) → 8 cycles; reg_write=1 only in cycle 8, with mem_to_reg=1 and reg_dst=00; iord=1 in cycles 6–7.
- R-type sub (funct 0x22) → alu_op=010 in R_EXEC; reg_write with reg_dst=01 in cycle 6; back to FETCH in cycle 7.
- beq with zero=1 → pc_write=1 and pc_source=01 in cycle 5; bne with zero=1 → pc_write=0 in cycle 5.
- Opcode 0x3F: with `MIPS_EXCEPTION_EN`, EXC in cycle 5 with epc_write=1 and pc_source=11; without it, FETCH in cycle 5 and reg_write never asserted.
- addi with overflow=1 under `MIPS_EXCEPTION_EN` → ADDI_EXEC → EXC, and reg_write stays 0.
